// File: rtl/pc_sequencer_if.sv
//------------------------------------------------------------------------------
// pc_sequencer_if : fetch-stage next-PC control bundle (PC register, hazard, ID redirect)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_cur;
  logic              stall;
  logic              imem_ready;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] pc_in;
  logic              le_pc;
  logic              if_flush;
  logic              align_err;
  logic [1:0]        seq_state;

  modport master (
    output pc_cur, stall, imem_ready, br_taken, br_target, jmp, jmp_target,
    input  pc_in, le_pc, if_flush, align_err, seq_state
  );

  modport slave (
    input  pc_cur, stall, imem_ready, br_taken, br_target, jmp, jmp_target,
    output pc_in, le_pc, if_flush, align_err, seq_state
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// pc_sequencer : next-PC controller with start-up hold, stall/wait hold and pending redirect
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int PC_STEP     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  pc_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [3:0]        C_HOLD_INIT = 4'(HOLD_CYCLES);
  localparam logic [ADDR_W-1:0] C_STEP      = ADDR_W'(PC_STEP);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_pend;
  logic [ADDR_W-1:0] w_pend_nxt;

  logic              w_redir;
  logic              w_go;
  logic [ADDR_W-1:0] w_raw_tgt;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_pend_sel;
  logic              w_misalign;

  // Jump wins over branch; the target is word-aligned before use or storage.
  assign w_redir    = bus.jmp | bus.br_taken;
  assign w_raw_tgt  = bus.jmp ? bus.jmp_target : bus.br_target;
  assign w_tgt      = {w_raw_tgt[ADDR_W-1:2], 2'b00};
  assign w_misalign = w_redir & (w_raw_tgt[1:0] != 2'b00);
  assign w_go       = bus.imem_ready & ~bus.stall;
  assign w_seq      = bus.pc_cur + C_STEP;
  assign w_pend_sel = w_redir ? w_tgt : r_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_HOLD;
      r_cnt   <= C_HOLD_INIT;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (r_state == ST_HOLD) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_nxt    = r_pend;
    bus.pc_in     = w_seq;
    bus.le_pc     = 1'b0;
    bus.if_flush  = 1'b0;
    bus.align_err = 1'b0;

    case (r_state)
      ST_HOLD: begin
        bus.pc_in = '0;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        bus.align_err = w_misalign;
        if (w_redir) begin
          if (w_go) begin
            bus.pc_in    = w_tgt;
            bus.le_pc    = 1'b1;
            bus.if_flush = 1'b1;
          end else begin
            w_pend_nxt  = w_tgt;
            w_state_nxt = ST_PEND;
          end
        end else begin
          bus.le_pc = w_go;
        end
      end

      ST_PEND: begin
        // A fresh redirect supersedes the stored one, whether or not it issues now.
        bus.align_err = w_misalign;
        if (w_go) begin
          bus.pc_in    = w_pend_sel;
          bus.le_pc    = 1'b1;
          bus.if_flush = 1'b1;
          w_state_nxt  = ST_RUN;
        end else begin
          w_pend_nxt = w_pend_sel;
        end
      end

      default: begin
        w_state_nxt = ST_HOLD;
      end
    endcase
  end

  assign bus.seq_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// tb_pc_sequencer : directed bench with a behavioural PC register closing the pc_in -> pc_cur loop
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic [31:0] load_val;
  logic [31:0] pc_reg;
  int          total;
  int          bad;

  pc_sequencer_if #(.ADDR_W(32)) bus ();

  pc_sequencer #(
    .ADDR_W      (32),
    .PC_STEP     (4),
    .HOLD_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register; load_req lets the bench plant an arbitrary PC value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= '0;
    end else if (load_req) begin
      pc_reg <= load_val;
    end else if (bus.le_pc) begin
      pc_reg <= bus.pc_in;
    end
  end

  assign bus.pc_cur = pc_reg;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input bit chk_pc, input logic [31:0] e_pc,
                     input logic e_le, input logic e_fl, input logic e_al,
                     input logic [1:0] e_st);
    @(negedge clk);
    if (chk_pc) cmp({tag, ".pc_in"}, bus.pc_in, e_pc);
    cmp({tag, ".le_pc"},     32'(bus.le_pc),     32'(e_le));
    cmp({tag, ".if_flush"},  32'(bus.if_flush),  32'(e_fl));
    cmp({tag, ".align_err"}, 32'(bus.align_err), 32'(e_al));
    cmp({tag, ".state"},     32'(bus.seq_state), 32'(e_st));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    load_req = 1'b0;
    load_val = '0;
    bus.stall = 1'b0;
    bus.imem_ready = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.jmp = 1'b0;
    bus.jmp_target = '0;

    // Reset: outputs quiet even with a misaligned redirect on the inputs
    step();
    bus.br_taken = 1'b1;
    bus.br_target = 32'h203;
    chk("rst", 1, 32'h0, 0, 0, 0, S_HOLD);
    bus.br_taken = 1'b0;
    step();
    reset = 1'b0;

    // Two hold cycles, then sequential 4, 8, 12
    chk("hold1", 1, 32'h0, 0, 0, 0, S_HOLD); step();
    chk("hold2", 1, 32'h0, 0, 0, 0, S_HOLD); step();
    chk("seq4",  1, 32'h4, 1, 0, 0, S_RUN);  step();
    chk("seq8",  1, 32'h8, 1, 0, 0, S_RUN);  step();
    chk("seq12", 1, 32'hC, 1, 0, 0, S_RUN);  step();

    // Memory wait without redirect, while planting PC=0x100
    bus.imem_ready = 1'b0;
    load_req = 1'b1;
    load_val = 32'h100;
    chk("idle", 1, 32'h10, 0, 0, 0, S_RUN); step();
    load_req = 1'b0;
    bus.imem_ready = 1'b1;

    // Taken branch with go
    bus.br_taken = 1'b1;
    bus.br_target = 32'h200;
    chk("br", 1, 32'h200, 1, 1, 0, S_RUN); step();
    bus.br_taken = 1'b0;
    chk("br_next", 1, 32'h204, 1, 0, 0, S_RUN); step();

    // Jump during 3-cycle stall goes pending, issues on release
    bus.stall = 1'b1;
    bus.jmp = 1'b1;
    bus.jmp_target = 32'h40;
    chk("stall_jmp", 0, 32'h0, 0, 0, 0, S_RUN); step();
    bus.jmp = 1'b0;
    chk("pend1", 0, 32'h0, 0, 0, 0, S_PEND); step();
    chk("pend2", 0, 32'h0, 0, 0, 0, S_PEND); step();
    bus.stall = 1'b0;
    chk("pend_rel", 1, 32'h40, 1, 1, 0, S_PEND); step();
    chk("jmp_next", 1, 32'h44, 1, 0, 0, S_RUN); step();

    // Second redirect while pending overwrites the first
    bus.stall = 1'b1;
    bus.jmp = 1'b1;
    bus.jmp_target = 32'h40;
    chk("ovr_a", 0, 32'h0, 0, 0, 0, S_RUN); step();
    bus.jmp = 1'b0;
    bus.br_taken = 1'b1;
    bus.br_target = 32'h80;
    chk("ovr_b", 0, 32'h0, 0, 0, 0, S_PEND); step();
    bus.br_taken = 1'b0;
    chk("ovr_hold", 0, 32'h0, 0, 0, 0, S_PEND); step();
    bus.stall = 1'b0;
    chk("ovr_rel", 1, 32'h80, 1, 1, 0, S_PEND); step();
    chk("ovr_next", 1, 32'h84, 1, 0, 0, S_RUN); step();

    // Pending from imem wait; new redirect in the releasing cycle wins
    bus.imem_ready = 1'b0;
    bus.jmp = 1'b1;
    bus.jmp_target = 32'h40;
    chk("wait_jmp", 0, 32'h0, 0, 0, 0, S_RUN); step();
    bus.jmp = 1'b0;
    bus.imem_ready = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 32'h90;
    chk("pend_new", 1, 32'h90, 1, 1, 0, S_PEND); step();
    bus.br_taken = 1'b0;
    chk("pend_new_next", 1, 32'h94, 1, 0, 0, S_RUN); step();

    // Jump beats branch; misaligned target
    bus.jmp = 1'b1;
    bus.jmp_target = 32'h300;
    bus.br_taken = 1'b1;
    bus.br_target = 32'h400;
    chk("jmp_wins", 1, 32'h300, 1, 1, 0, S_RUN); step();
    bus.jmp = 1'b0;
    bus.br_target = 32'h203;
    chk("align", 1, 32'h200, 1, 1, 1, S_RUN); step();
    bus.br_taken = 1'b0;
    chk("align_next", 1, 32'h204, 1, 0, 0, S_RUN); step();

    // Address wrap
    bus.imem_ready = 1'b0;
    load_req = 1'b1;
    load_val = 32'hFFFF_FFFC;
    step();
    load_req = 1'b0;
    bus.imem_ready = 1'b1;
    chk("wrap", 1, 32'h0, 1, 0, 0, S_RUN); step();
    chk("wrap_next", 1, 32'h4, 1, 0, 0, S_RUN); step();

    // Reset while pending drops the pending target
    bus.stall = 1'b1;
    bus.jmp = 1'b1;
    bus.jmp_target = 32'h40;
    step();
    bus.jmp = 1'b0;
    chk("pre_rst", 0, 32'h0, 0, 0, 0, S_PEND);
    #1 reset = 1'b1;
    #1;
    cmp("mid_rst.state",  32'(bus.seq_state), 32'(S_HOLD));
    cmp("mid_rst.le_pc",  32'(bus.le_pc),     32'h0);
    cmp("mid_rst.pc_in",  bus.pc_in,          32'h0);
    step();
    bus.stall = 1'b0;
    step();
    reset = 1'b0;
    chk("rst2_hold1", 1, 32'h0, 0, 0, 0, S_HOLD); step();
    chk("rst2_hold2", 1, 32'h0, 0, 0, 0, S_HOLD); step();
    chk("rst2_run",   1, 32'h4, 1, 0, 0, S_RUN);  step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
